// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: fetches one instruction per cycle from a
// combinational instruction memory and buffers {instr, pc} for issue.
module inst_fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int INSTR_W  = 32,
  parameter int ADDR_W   = 8,
  parameter int PROG_LEN = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]     imem_data,
  output logic                   iq_valid,
  output logic [INSTR_W-1:0]     iq_instr,
  output logic [ADDR_W-1:0]      iq_pc,
  input  logic                   issue_ready,
  input  logic                   flush,
  input  logic [ADDR_W-1:0]      flush_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic                   fetch_done,
  output logic                   drained
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]  PROG_END = (ADDR_W+1)'(PROG_LEN);
  localparam logic [ADDR_W:0]  PC_ONE   = (ADDR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   FULL     = (PTR_W+1)'(DEPTH);

  // One extra PC bit so the saturation point PROG_LEN == 2^ADDR_W is representable.
  logic [ADDR_W:0]    pc;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [INSTR_W-1:0] mem_instr [DEPTH];
  logic [ADDR_W-1:0]  mem_pc    [DEPTH];
  logic               push;
  logic               pop;

  assign fetch_done = (pc >= PROG_END);
  assign iq_valid   = (count != '0);
  assign pop        = iq_valid && issue_ready;
  assign push       = !fetch_done && ((count < FULL) || pop);
  assign imem_addr  = pc[ADDR_W-1:0];
  assign iq_instr   = mem_instr[head];
  assign iq_pc      = mem_pc[head];
  assign drained    = fetch_done && !iq_valid;

  // Flush wins over push and pop; a head offered during a flush is not consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      pc    <= {1'b0, flush_pc};
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_ONE;
        pc   <= pc + PC_ONE;
      end
      if (pop) begin
        head <= head + PTR_ONE;
      end
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // Storage needs no reset: entries are only observable through count.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_instr[tail] <= imem_data;
      mem_pc[tail]    <= pc[ADDR_W-1:0];
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized scoreboard bench for inst_fetch_queue against a queue-based
// model of the program stream.
module tb_inst_fetch_queue;

  localparam int DEPTH    = 4;
  localparam int INSTR_W  = 32;
  localparam int ADDR_W   = 8;
  localparam int PROG_LEN = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [ADDR_W-1:0]      imem_addr;
  logic [INSTR_W-1:0]     imem_data;
  logic                   iq_valid;
  logic [INSTR_W-1:0]     iq_instr;
  logic [ADDR_W-1:0]      iq_pc;
  logic                   issue_ready;
  logic                   flush;
  logic [ADDR_W-1:0]      flush_pc;
  logic [$clog2(DEPTH):0] count;
  logic                   fetch_done;
  logic                   drained;

  int checks = 0;
  int errors = 0;
  int model_q[$];
  int sb_q[$];
  int model_pc = 0;

  inst_fetch_queue #(
    .DEPTH(DEPTH), .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN)
  ) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .iq_valid(iq_valid), .iq_instr(iq_instr), .iq_pc(iq_pc),
    .issue_ready(issue_ready), .flush(flush), .flush_pc(flush_pc),
    .count(count), .fetch_done(fetch_done), .drained(drained)
  );

  always #5 clk = ~clk;

  assign imem_data = 32'h1000_0000 + 32'(imem_addr);

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput();
    bit done;
    done = (model_pc >= PROG_LEN);
    checkVal("count", 32'(count), 32'(model_q.size()));
    checkVal("iq_valid", 32'(iq_valid), 32'(model_q.size() != 0));
    checkVal("imem_addr", 32'(imem_addr), 32'(model_pc));
    checkVal("fetch_done", 32'(fetch_done), 32'(done));
    checkVal("drained", 32'(drained), 32'(done && model_q.size() == 0));
    if (model_q.size() != 0) begin
      checkVal("head_pc", 32'(iq_pc), 32'(model_q[0]));
      checkVal("head_instr", iq_instr, 32'h1000_0000 + 32'(model_q[0]));
    end
  endtask

  // Advance the program-stream model across the coming clock edge.
  task automatic predict();
    bit pop;
    bit push;
    pop  = (model_q.size() != 0) && issue_ready;
    push = (model_pc < PROG_LEN) && (model_q.size() < DEPTH || pop);
    if (flush) begin
      model_q.delete();
      model_pc = int'(flush_pc);
    end else begin
      if (pop) sb_q.push_back(model_q.pop_front());
      if (push) begin
        model_q.push_back(model_pc);
        model_pc++;
      end
    end
  endtask

  task automatic applyStimulus(input bit rdy, input bit fl, input logic [ADDR_W-1:0] fpc);
    issue_ready = rdy;
    flush       = fl;
    flush_pc    = fpc;
    @(negedge clk);
    checkOutput();
    predict();
    @(posedge clk);
    #1;
  endtask

  // Handoff monitor: every accepted head must match the next scoreboard entry.
  initial begin
    int exp_pc;
    forever begin
      @(negedge clk);
      #1;
      if (rst === 1'b1 && iq_valid === 1'b1 && issue_ready === 1'b1 && flush === 1'b0) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL handoff: got pc 0x%0h, want no pop at %0t", iq_pc, $time);
        end else begin
          exp_pc = sb_q.pop_front();
          checkVal("handoff_pc", 32'(iq_pc), 32'(exp_pc));
          checkVal("handoff_instr", iq_instr, 32'h1000_0000 + 32'(exp_pc));
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    issue_ready = 1'b0;
    flush = 1'b0;
    flush_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    repeat (20) applyStimulus(1'b1, 1'b0, 8'd0);

    applyStimulus(1'b0, 1'b1, 8'd0);
    repeat (6) applyStimulus(1'b0, 1'b0, 8'd0);
    applyStimulus(1'b1, 1'b0, 8'd0);
    repeat (2) applyStimulus(1'b0, 1'b0, 8'd0);
    repeat (3) applyStimulus(1'b1, 1'b0, 8'd0);

    applyStimulus(1'b0, 1'b1, 8'd2);
    repeat (5) applyStimulus(1'b0, 1'b0, 8'd0);
    applyStimulus(1'b1, 1'b1, 8'd9);
    repeat (3) applyStimulus(1'b1, 1'b0, 8'd0);

    applyStimulus(1'b1, 1'b1, 8'd16);
    repeat (3) applyStimulus(1'($urandom % 2), 1'b0, 8'd0);

    // Reset asserted between edges with three entries queued.
    applyStimulus(1'b0, 1'b1, 8'd0);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'd0);
    checkVal("pre_reset_count", 32'(count), 32'd3);
    #1 rst = 1'b0;
    #1;
    checkVal("async_count", 32'(count), 32'd0);
    checkVal("async_iq_valid", 32'(iq_valid), 32'd0);
    checkVal("async_imem_addr", 32'(imem_addr), 32'd0);
    model_q.delete();
    sb_q.delete();
    model_pc = 0;
    #1 rst = 1'b1;
    repeat (6) applyStimulus(1'b1, 1'b0, 8'd0);

    for (int i = 0; i < 400; i++) begin
      bit rdy;
      rdy = ((i / 50) % 2 == 1) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
      applyStimulus(rdy, ($urandom % 25) == 0, ADDR_W'($urandom_range(0, 18)));
    end
    repeat (25) applyStimulus(1'b1, 1'b0, 8'd0);
    checkVal("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Front-end stage of the single-issue Tomasulo core. Fetches one instruction per cycle from a combinational-read instruction memory, buffers up to DEPTH instructions with their PCs in a circular FIFO, and presents the head to the issue stage through a valid/ready handshake. It raises `drained` once the whole program has been fetched and handed off; the top level uses this to build its `done` output.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- INSTR_W, 32: instruction width.
- ADDR_W, 8: PC / instruction-memory address width (word addressed).
- PROG_LEN, 16: number of instructions in the program; fetch stops at PC == PROG_LEN; must be at most 2^ADDR_W.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low: low resets, high runs.
- imem_addr  out  ADDR_W  fetch address; always equals the internal PC.
- imem_data  in  INSTR_W  instruction at imem_addr, valid in the same cycle.
- iq_valid  out  1  head entry valid.
- iq_instr  out  INSTR_W  head instruction.
- iq_pc  out  ADDR_W  PC of the head instruction.
- issue_ready  in  1  issue stage accepts the head this cycle.
- flush  in  1  discard all entries and redirect fetch.
- flush_pc  in  ADDR_W  new fetch PC when flush is high.
- count  out  $clog2(DEPTH)+1  occupied entries.
- fetch_done  out  1  PC >= PROG_LEN.
- drained  out  1  fetch_done && count == 0.

## Operation
- State: PC, head pointer, tail pointer, count, and storage of DEPTH × {instr, pc}. The pointers wrap modulo DEPTH.
- pop = iq_valid && issue_ready.
- push = !fetch_done && (count < DEPTH || pop).
  - A push is allowed when the queue is full if a pop happens in the same cycle.
- On push:
  - mem[tail] <= {imem_data, PC}.
  - tail <= tail+1.
  - PC <= PC+1.
- On pop: head <= head+1.
- Count update: count <= count + push − pop.
- Head outputs are combinational:
  - iq_valid = (count != 0).
  - iq_instr and iq_pc come from mem[head].
  - When empty, iq_instr and iq_pc are don't-care; the bench checks them only when iq_valid is high.
- Flush has priority over push and pop in the same cycle:
  - head <= 0, tail <= 0, count <= 0.
  - PC <= flush_pc.
  - The entry at the head is not considered consumed, even if issue_ready was high.
- Flush to flush_pc >= PROG_LEN: fetch_done is high and nothing is fetched.
- The PC saturates at PROG_LEN: no increment once fetch_done is high.
- After fetch_done, the queue only drains. drained rises in the cycle after the last pop.
- Reset mid-operation: all state clears immediately (asynchronous); no partial entry survives.

## Timing
- Reset values:
  - PC = 0, head = 0, tail = 0, count = 0.
  - iq_valid = 0, imem_addr = 0.
  - fetch_done = 0 (1 only when PROG_LEN == 0).
  - drained = fetch_done.
- Fetch-to-issue latency: the instruction at address A is fetched in cycle N and visible at the head in cycle N+1.
  - Minimum occupancy of one cycle; there is no bypass from imem_data to iq_instr.
- Throughput: with issue_ready held high, one push and one pop per cycle, and count stays at 1.
- With issue_ready low, the queue fills to DEPTH after DEPTH fetch cycles. imem_addr then holds at the next PC.
- Flush takes effect at the clock edge:
  - In the next cycle, iq_valid = 0 and imem_addr = flush_pc.
  - The first redirected instruction is valid one cycle after that.
- Handshake:
  - iq_instr and iq_pc stay stable while iq_valid is high and issue_ready is low; a push never overwrites the head.
  - The issue stage may change issue_ready at any time; it is sampled at the rising edge.

## Test plan
- Reset then free run, issue_ready = 1, PROG_LEN = 16, imem_data = 0x1000_0000 + addr:
  - iq_valid rises 1 cycle after reset release.
  - iq_pc runs 0..15 on consecutive cycles with matching iq_instr.
  - fetch_done rises after PC 15 is fetched.
  - drained is high 1 cycle after the pop of PC 15.
- Backpressure, issue_ready = 0 from reset:
  - count goes 1, 2, 3, 4 and then holds at 4.
  - imem_addr holds at 4; the head stays at pc 0.
  - Raising issue_ready then gives pops of pc 0, 1, 2, 3, 4, … with no gap and no duplicate.
- Full with simultaneous push/pop: count = 4, pulse issue_ready for 1 cycle:
  - count stays 4.
  - The head advances to pc 1.
  - The entry for pc 4 is written to the freed slot; FIFO order is preserved across wrap-around.
- Flush with pop in the same cycle: queue holds pc 2..5, assert flush with flush_pc = 9 and issue_ready = 1:
  - Next cycle: count = 0, iq_valid = 0, imem_addr = 9.
  - The following cycle: iq_pc = 9.
- Flush to end of program: flush_pc = 16 with PROG_LEN = 16:
  - fetch_done = 1 and drained = 1 the next cycle.
  - No further pushes occur.
- Asynchronous reset mid-run: drive rst low between clock edges while count = 3:
  - count = 0, iq_valid = 0 and imem_addr = 0 immediately, without waiting for a clock edge.
  - After rst returns high, the fetch restarts from pc 0.
